// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state and transaction owner.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } arb_owner_t;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starvation counter for port B with a limit compare.
module dmem_arb_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign hit = (cnt >= CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory arbiter (A = MEM stage, B = debug/loader) with response timeout.
// Optional B starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_wstrb,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_wstrb,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic        m_err,
  input  logic [31:0] m_rdata,
  output logic        stall_m
);

  arb_state_t       state, state_nxt;
  arb_owner_t       owner, owner_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             starve_hit;
  logic             b_wins;
  logic             rsp_valid, rsp_err;
  logic [31:0]      rsp_data;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic starve_inc;
  assign starve_inc = (state == IDLE) && b_req && !b_gnt;

  dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (b_gnt),
    .hit   (starve_hit)
  );
`else
  // Strict A priority; STARVE_LIMIT is never 0, so this is constant low.
  assign starve_hit = (STARVE_LIMIT == 0);
`endif

  assign b_wins = b_req && (!a_req || starve_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWNER_A;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // Outputs are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    tmo_cnt_nxt = tmo_cnt;
    m_req       = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_wstrb     = '0;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_data    = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            m_req = 1'b1;
            if (b_wins) begin
              m_we    = b_we;
              m_addr  = b_addr;
              m_wdata = b_wdata;
              m_wstrb = b_wstrb;
              b_gnt   = m_gnt;
            end else begin
              m_we    = a_we;
              m_addr  = a_addr;
              m_wdata = a_wdata;
              m_wstrb = a_wstrb;
              a_gnt   = m_gnt;
            end
            if (m_gnt) begin
              owner_nxt   = b_wins ? OWNER_B : OWNER_A;
              tmo_cnt_nxt = '0;
              state_nxt   = WAIT;
            end
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            rsp_valid = 1'b1;
            rsp_err   = m_err;
            rsp_data  = m_rdata;
            state_nxt = IDLE;
          end else if (tmo_cnt >= CNT_W'(TIMEOUT - 1)) begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
            state_nxt = DRAIN;
          end else if (tmo_cnt != '1) begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (m_rvalid)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign a_rvalid = rsp_valid && (owner == OWNER_A);
  assign a_err    = rsp_err   && (owner == OWNER_A);
  assign a_rdata  = (owner == OWNER_A) ? rsp_data : '0;
  assign b_rvalid = rsp_valid && (owner == OWNER_B);
  assign b_err    = rsp_err   && (owner == OWNER_B);
  assign b_rdata  = (owner == OWNER_B) ? rsp_data : '0;

  assign stall_m = !reset &&
                   ((a_req && !a_gnt) ||
                    (state != IDLE && owner == OWNER_A && !a_rvalid));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (TIMEOUT=4, STARVE_LIMIT=3).
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk, reset;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic        b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_wstrb;
  logic        m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        stall_m;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          exp_b;

  dmem_port_arbiter #(.TIMEOUT(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .stall_m(stall_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    m_gnt = 0; m_rvalid = 0; m_err = 0; m_rdata = '0;

    // Reset: outputs forced low even with a request and memory accept present.
    #2 a_req = 1; m_gnt = 1;
    @(negedge clk);
    check("rst_m_req",   m_req,   0);
    check("rst_a_gnt",   a_gnt,   0);
    check("rst_stall",   stall_m, 0);
    check("rst_a_rval",  a_rvalid, 0);
    next_cyc();
    a_req = 0; m_gnt = 0;
    next_cyc();
    reset = 0;

    // A read at 0x100: memory holds off one cycle, then grants, responds next cycle.
    a_req = 1; a_addr = 32'h100; a_we = 0; a_wstrb = 4'hF;
    @(negedge clk);
    check("rd_wait_m_req",  m_req,  1);
    check("rd_wait_m_addr", m_addr, 32'h100);
    check("rd_wait_a_gnt",  a_gnt,  0);
    check("rd_wait_stall",  stall_m, 1);
    next_cyc();
    m_gnt = 1;
    @(negedge clk);
    check("rd_c0_a_gnt", a_gnt,   1);
    check("rd_c0_b_gnt", b_gnt,   0);
    check("rd_c0_stall", stall_m, 0);
    next_cyc();
    a_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rd_c1_a_rval",  a_rvalid, 1);
    check("rd_c1_a_rdata", a_rdata,  32'hDEADBEEF);
    check("rd_c1_a_err",   a_err,    0);
    check("rd_c1_b_rval",  b_rvalid, 0);
    check("rd_c1_m_req",   m_req,    0);
    check("rd_c1_stall",   stall_m,  0);
    next_cyc();
    // Stray response in IDLE must be ignored.
    @(negedge clk);
    check("idle_ign_a_rval", a_rvalid, 0);
    check("idle_ign_a_rdat", a_rdata,  0);
    next_cyc();

    // A and B request continuously; memory grants and answers immediately.
    a_req = 1; b_req = 1; a_addr = 32'hA0; b_addr = 32'hB0;
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h77;
    for (int k = 0; k < 5; k++) begin
      exp_b = STARVE_ON && (k == 3);
      @(negedge clk);
      check($sformatf("arb%0d_a_gnt", k),  a_gnt,   !exp_b);
      check($sformatf("arb%0d_b_gnt", k),  b_gnt,   exp_b);
      check($sformatf("arb%0d_m_addr", k), m_addr,  exp_b ? 32'hB0 : 32'hA0);
      check($sformatf("arb%0d_stall", k),  stall_m, exp_b);
      next_cyc();
      @(negedge clk);
      check($sformatf("rsp%0d_a_rval", k), a_rvalid, !exp_b);
      check($sformatf("rsp%0d_b_rval", k), b_rvalid, exp_b);
      check($sformatf("rsp%0d_m_req", k),  m_req,    0);
      next_cyc();
    end

    // A write with no answer: timeout error 4 cycles after grant.
    b_req = 0; m_rvalid = 0;
    a_req = 1; a_we = 1; a_addr = 32'h200; a_wdata = 32'h1234; a_wstrb = 4'hF;
    @(negedge clk);
    check("to_c0_a_gnt",   a_gnt,   1);
    check("to_c0_m_we",    m_we,    1);
    check("to_c0_m_wdata", m_wdata, 32'h1234);
    next_cyc();
    a_req = 0; a_we = 0; m_gnt = 0; m_rdata = 32'h55;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("to_c%0d_a_rval", c), a_rvalid, 0);
      check($sformatf("to_c%0d_stall", c),  stall_m,  1);
      next_cyc();
    end
    @(negedge clk);
    check("to_c4_a_rval",  a_rvalid, 1);
    check("to_c4_a_err",   a_err,    1);
    check("to_c4_a_rdata", a_rdata,  0);
    check("to_c4_stall",   stall_m,  0);
    next_cyc();
    // DRAIN: B requests but cannot be granted until the late response arrives.
    b_req = 1; b_we = 1; b_addr = 32'h300; b_wdata = 32'hCAFE; b_wstrb = 4'h3; m_gnt = 1;
    for (int c = 5; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("dr_c%0d_b_gnt", c), b_gnt, 0);
      check($sformatf("dr_c%0d_m_req", c), m_req, 0);
      next_cyc();
    end
    m_rvalid = 1;
    @(negedge clk);
    check("dr_c7_a_rval", a_rvalid, 0);
    check("dr_c7_b_rval", b_rvalid, 0);
    next_cyc();
    m_rvalid = 0;
    @(negedge clk);
    check("bw_b_gnt",   b_gnt,   1);
    check("bw_m_addr",  m_addr,  32'h300);
    check("bw_m_wstrb", m_wstrb, 4'h3);
    check("bw_m_we",    m_we,    1);
    next_cyc();
    // B write faults at the memory.
    b_req = 0; b_we = 0; m_gnt = 0; m_rvalid = 1; m_err = 1;
    @(negedge clk);
    check("bw_b_rval",  b_rvalid, 1);
    check("bw_b_err",   b_err,    1);
    check("bw_b_rdata", b_rdata,  32'h55);
    check("bw_a_rval",  a_rvalid, 0);
    check("bw_a_err",   a_err,    0);
    check("bw_a_rdata", a_rdata,  0);
    check("bw_stall",   stall_m,  0);
    next_cyc();
    m_rvalid = 0; m_err = 0;

    // Reset pulsed mid-WAIT, then a stray response.
    a_req = 1; a_addr = 32'h400; m_gnt = 1;
    @(negedge clk);
    check("rw_a_gnt", a_gnt, 1);
    next_cyc();
    a_req = 0; m_gnt = 0;
    @(negedge clk);
    check("rw_wait_stall", stall_m, 1);
    #2 reset = 1; a_req = 1; m_gnt = 1;
    #1;
    check("rw_rst_stall", stall_m, 0);
    check("rw_rst_m_req", m_req,   0);
    check("rw_rst_a_gnt", a_gnt,   0);
    next_cyc();
    reset = 0; a_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h99;
    @(negedge clk);
    check("rw_stray_a_rval", a_rvalid, 0);
    check("rw_stray_b_rval", b_rvalid, 0);
    check("rw_stray_stall",  stall_m,  0);
    next_cyc();
    m_rvalid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
